mem_wb_multi: RTL

- Parametrised successor to the single-lane MEM→WB pipeline register.
- Carries LANES independent writeback lanes from the memory stage to register-file writeback, each with an explicit write-enable.
- Adds flush, same-cycle write-after-write resolution between lanes, x0 write suppression and a retired-write counter.
- Sits between the memory stage and the register file / forwarding network.

---
 rtl/mem_wb_multi.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM->WB pipeline register with flush, lane write-after-write resolution,
// x0 suppression and retired-write counter. Define MEM_WB_MULTI_PERF_EN for stall/bubble counters.
module mem_wb_multi #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RAW        = 5,
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned HOLD_BIT   = 5,
  parameter int unsigned BUBBLE_BIT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [STALL_W-1:0]      stall_in,
  input  logic                    flush_in,
  input  logic [LANES-1:0]        rd_we_in,
  input  logic [LANES*RAW-1:0]    rd_address_in,
  input  logic [LANES*XLEN-1:0]   rd_data_in,
  output logic [LANES-1:0]        rd_we,
  output logic [LANES*RAW-1:0]    rd_address,
  output logic [LANES*XLEN-1:0]   rd_data,
  output logic [CNT_W-1:0]        retire_cnt
`ifdef MEM_WB_MULTI_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
`endif
);

  localparam int unsigned AW = LANES * RAW;
  localparam int unsigned DW = LANES * XLEN;

  logic [LANES-1:0] rd_we_q,      rd_we_d;
  logic [AW-1:0]    rd_address_q, rd_address_d;
  logic [DW-1:0]    rd_data_q,    rd_data_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic [LANES-1:0] qual_we_c;
  logic [CNT_W-1:0] qual_cnt_c;
  logic             hold_c;
  logic             bubble_c;
  logic             unused_stall_c;

  // Only the hold and bubble bits of the shared stall vector matter here.
  assign unused_stall_c = ^stall_in;
  assign hold_c         = stall_in[HOLD_BIT];
  assign bubble_c       = stall_in[BUBBLE_BIT];

  // A lane commits only if enabled, not x0, and not overwritten by a younger lane.
  always_comb begin
    qual_we_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      qual_we_c[i] = rd_we_in[i] && (rd_address_in[i*RAW +: RAW] != '0);
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (rd_we_in[j] && (rd_address_in[j*RAW +: RAW] == rd_address_in[i*RAW +: RAW])) begin
          qual_we_c[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    qual_cnt_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      qual_cnt_c = qual_cnt_c + CNT_W'(qual_we_c[i]);
    end
  end

`ifdef MEM_WB_MULTI_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
`endif

  // Next-state selection: ready, flush, hold, bubble, load in priority order.
  always_comb begin
    rd_we_d      = rd_we_q;
    rd_address_d = rd_address_q;
    rd_data_d    = rd_data_q;
    retire_cnt_d = retire_cnt_q;
`ifdef MEM_WB_MULTI_PERF_EN
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
`endif
    if (!rdy_in) begin
      rd_we_d = rd_we_q;
    end else if (flush_in) begin
      rd_we_d      = '0;
      rd_address_d = '0;
      rd_data_d    = '0;
    end else if (hold_c) begin
`ifdef MEM_WB_MULTI_PERF_EN
      stall_cnt_d  = stall_cnt_q + CNT_W'(1);
`endif
    end else if (bubble_c) begin
      rd_we_d      = '0;
      rd_address_d = '0;
      rd_data_d    = '0;
`ifdef MEM_WB_MULTI_PERF_EN
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
`endif
    end else begin
      rd_we_d      = qual_we_c;
      rd_address_d = rd_address_in;
      rd_data_d    = rd_data_in;
      retire_cnt_d = retire_cnt_q + qual_cnt_c;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_we_q      <= '0;
      rd_address_q <= '0;
      rd_data_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      rd_we_q      <= rd_we_d;
      rd_address_q <= rd_address_d;
      rd_data_q    <= rd_data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef MEM_WB_MULTI_PERF_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

  assign rd_we      = rd_we_q;
  assign rd_address = rd_address_q;
  assign rd_data    = rd_data_q;
  assign retire_cnt = retire_cnt_q;

endmodule
